fpu_norm_round: RTL and testbench
=================================

# fpu_norm_round

Two-stage pipelined normalize-and-round unit for the private FPU. It consumes the unnormalized magnitude produced by the add/mul datapath and locates the leading one with an internal fpu_ff instance. It shifts the mantissa, adjusts the exponent, rounds per the RISC-V rounding mode and packs an IEEE-754 result with fflags. It sits between the arithmetic core and the FPU result/writeback interface, using a valid/ready handshake on both sides.

## Interface
- EXP_WIDTH, 8: result exponent width; bias = 2^(EXP_WIDTH-1)-1.
- MANT_WIDTH, 23: stored fraction width.
- MANT_IN_WIDTH, MANT_WIDTH+4: input magnitude width; must equal MANT_WIDTH+4.
- TAG_WIDTH, 4: opaque tag carried alongside each operation.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight operations.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  input accepted when in_valid_i & in_ready_o.
- in_sign_i  in  1  result sign.
- in_exp_i  in  EXP_WIDTH+2  signed biased exponent of the input.
- in_mant_i  in  MANT_IN_WIDTH  magnitude: bit MANT_IN_WIDTH-1 has weight 2^1 and bit MANT_IN_WIDTH-2 has weight 2^0 (hidden position); value = mant/2^(MANT_IN_WIDTH-2) * 2^(in_exp_i-bias).
- in_rm_i  in  3  RISC-V rounding mode (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100; other codes are treated as RNE).
- in_tag_i  in  TAG_WIDTH  tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- out_result_o  out  1+EXP_WIDTH+MANT_WIDTH  packed {sign, exp, frac}.
- out_flags_o  out  5  {NV,DZ,OF,UF,NX}; NV and DZ are always 0.
- out_tag_o  out  TAG_WIDTH  tag of the result.

## Operation
- Stage 1 (LOD/shift):
  - fpu_ff (LEN=MANT_IN_WIDTH) returns lz = leading-one index from the MSB.
  - Shift the mantissa left by lz; exp1 = in_exp_i + 1 - lz, computed at EXP_WIDTH+2 bits signed.
  - Register the result with sign, rm, tag and a zero flag (no_ones).
- Stage 2 (round/pack):
  - After the MSB: next MANT_WIDTH bits = frac, next bit = guard, OR of remaining bits = sticky.
  - Round-up decision:
    - RNE: guard & (sticky | frac[0]).
    - RTZ: never.
    - RDN: (guard|sticky) & sign.
    - RUP: (guard|sticky) & ~sign.
    - RMM: guard.
  - NX = guard | sticky.
  - A rounding carry out of frac increments the exponent and clears frac.
- Zero input: result = {sign, 0, 0}, flags 0.
- Overflow (final exp >= 2^EXP_WIDTH-1):
  - Set OF and NX.
  - Result is ±inf for RNE/RMM, for RUP when positive and for RDN when negative; otherwise ±max finite (exp 2^EXP_WIDTH-2, frac all ones).
- Underflow (exp1 <= 0) is handled per Configuration.
- Handshake:
  - Elastic two-register pipeline; each stage keeps a valid bit.
  - s2 accepts when ~s2_valid | out_ready_i; s1 accepts when ~s1_valid | s2 accepts; in_ready_o = s1 accepts.
  - The combinational ready path is intentional.
  - A stalled stage holds all its data stable.
- flush_i clears both valid bits on the next edge and suppresses any acceptance in the same cycle.

## Timing
- Latency is 2 cycles from input acceptance to out_valid_o when not stalled; throughput is 1 per cycle.
- Reset values: out_valid_o=0 and internal valids=0. out_result_o, out_flags_o and out_tag_o read 0. in_ready_o=1 after reset.
- Reset asserted mid-operation discards all in-flight operations immediately (asynchronous).
- With out_ready_i low, at most 2 operations are held; in_ready_o drops once both stages are full.
- Output order equals input order.

## Configuration
- FPU_NORM_SUBNORM_EN defined:
  - When exp1 <= 0, right-shift the normalized mantissa by 1-exp1 before rounding, with shifted-out bits ORed into sticky; exponent field = 0.
  - A rounding carry into the hidden position yields exponent 1.
  - UF is set only when the result is tiny and NX is set.
- Undefined: when exp1 <= 0, the result is flushed to {sign,0,0} with UF and NX set (flush-to-zero).

## Test plan
- mant=27'h2000000, exp=127, sign=0, RNE -> 0x3F800000, flags 0, out_valid_o exactly 2 cycles after acceptance.
- mant=27'h4000000, exp=127 -> 0x40000000 (carry normalization); mant=27'h0000001, exp=152 -> 0x3F800000.
- Rounding, mant=27'h2000002 exp=127:
  - RNE -> 0x3F800000, flags 5'b00001.
  - mant=27'h2000006 RNE -> 0x3F800002.
  - mant=27'h2000002 RUP -> 0x3F800001.
  - RDN with sign=1 -> 0xBF800001.
- Overflow, mant=27'h7FFFFFF exp=254:
  - RNE -> 0x7F800000, flags 5'b00101.
  - RTZ -> 0x7F7FFFFF, flags 5'b00101.
  - Zero mant, sign=1 -> 0x80000000, flags 0.
- Underflow, exp=0 mant=27'h2000000:
  - With FPU_NORM_SUBNORM_EN -> 0x00400000, flags 0.
  - Without -> 0x00000000, flags 5'b00011.
- Backpressure/flush:
  - Offer 4 back-to-back ops with out_ready_i low -> in_ready_o low after 2 accepted. Raising ready delivers all 4 in order with no loss or duplication.
  - flush_i with 2 in flight -> out_valid_o=0 next cycle.

Source files
------------

// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalize, round and pack an FPU result; define FPU_NORM_SUBNORM_EN for gradual underflow (default flush-to-zero).
// Latency 2 cycles at 1 op/cycle; elastic valid/ready where a stalled stage holds its data and in_ready_o drops when both stages are full.

module fpu_ff #(
  parameter int LEN = 27,
  parameter int LZW = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic [LEN-1:0] in_i,
  output logic [LZW-1:0] lz_o,
  output logic           no_ones_o
);
  // The highest set bit is visited last, so it wins.
  always_comb begin
    lz_o = '0;
    for (int i = 0; i < LEN; i++) begin
      if (in_i[i]) lz_o = LZW'(LEN - 1 - i);
    end
  end

  assign no_ones_o = ~|in_i;
endmodule

module fpu_norm_round #(
  parameter int EXP_WIDTH     = 8,
  parameter int MANT_WIDTH    = 23,
  parameter int MANT_IN_WIDTH = MANT_WIDTH + 4,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              in_sign_i,
  input  logic [EXP_WIDTH+1:0]              in_exp_i,
  input  logic [MANT_IN_WIDTH-1:0]          in_mant_i,
  input  logic [2:0]                        in_rm_i,
  input  logic [TAG_WIDTH-1:0]              in_tag_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     out_result_o,
  output logic [4:0]                        out_flags_o,
  output logic [TAG_WIDTH-1:0]              out_tag_o
);
  localparam int EW  = EXP_WIDTH + 2;
  localparam int LZW = $clog2(MANT_IN_WIDTH);
  localparam int RW  = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int GB  = MANT_IN_WIDTH - MANT_WIDTH - 2;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic signed [EW:0] EXP_OVF = {3'b000, {EXP_WIDTH{1'b1}}};

  typedef struct packed {
    logic                     sign;
    logic [EW-1:0]            exp;
    logic [MANT_IN_WIDTH-1:0] mant;
    logic [2:0]               rm;
    logic [TAG_WIDTH-1:0]     tag;
    logic                     zero;
  } s1_t;

  typedef struct packed {
    logic [RW-1:0]        result;
    logic [4:0]           flags;
    logic [TAG_WIDTH-1:0] tag;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_accept, s2_accept, s1_load, s2_load;

  logic [LZW-1:0] lz;
  logic           no_ones;

  fpu_ff #(
    .LEN (MANT_IN_WIDTH),
    .LZW (LZW)
  ) u_ff (
    .in_i      (in_mant_i),
    .lz_o      (lz),
    .no_ones_o (no_ones)
  );

  // Handshake: the ready chain is combinational from out_ready_i back to in_ready_o.
  always_comb begin
    s2_accept  = ~s2_valid_q | out_ready_i;
    s1_accept  = (~s1_valid_q | s2_accept) & ~flush_i;
    s1_load    = s1_accept & in_valid_i;
    s2_load    = s2_accept & s1_valid_q & ~flush_i;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_accept) s1_valid_d = in_valid_i;
      if (s2_accept) s2_valid_d = s1_valid_q;
    end
  end

  assign in_ready_o = s1_accept;

  always_comb begin
    s1_d = s1_q;
    if (s1_load) begin
      s1_d.sign = in_sign_i;
      s1_d.exp  = in_exp_i + EW'(1) - EW'(lz);
      s1_d.mant = in_mant_i << lz;
      s1_d.rm   = in_rm_i;
      s1_d.tag  = in_tag_i;
      s1_d.zero = no_ones;
    end
  end

  logic                     tiny;
  logic [MANT_IN_WIDTH-1:0] mant_a;
  logic                     lost;
  logic [MANT_WIDTH-1:0]    frac;
  logic                     guard, sticky, inexact, round_up, uf;
  logic [2:0]               rm_eff;
  logic [MANT_WIDTH:0]      frac_sum;
  logic signed [EW:0]       exp_fin;
  logic                     ovf, to_inf;

  // Non-positive exp1 means the value is below the smallest normal.
  assign tiny = s1_q.exp[EW-1] | ~|s1_q.exp;

`ifdef FPU_NORM_SUBNORM_EN
  logic [EW:0] sub_shift;

  always_comb begin
    sub_shift = '0;
    if (tiny) sub_shift = {{EW{1'b0}}, 1'b1} - {s1_q.exp[EW-1], s1_q.exp};
  end

  assign mant_a = s1_q.mant >> sub_shift;
  assign lost   = |(s1_q.mant & ~({MANT_IN_WIDTH{1'b1}} << sub_shift));
`else
  assign mant_a = s1_q.mant;
  assign lost   = 1'b0;
`endif

  always_comb begin
    frac    = mant_a[MANT_IN_WIDTH-2 -: MANT_WIDTH];
    guard   = mant_a[GB];
    sticky  = (|mant_a[GB-1:0]) | lost;
    inexact = guard | sticky;
    rm_eff  = (s1_q.rm > RM_RMM) ? RM_RNE : s1_q.rm;
    case (rm_eff)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = inexact & s1_q.sign;
      RM_RUP:  round_up = inexact & ~s1_q.sign;
      RM_RMM:  round_up = guard;
      default: round_up = guard & (sticky | frac[0]);
    endcase
    frac_sum = {1'b0, frac} + {{MANT_WIDTH{1'b0}}, round_up};
`ifdef FPU_NORM_SUBNORM_EN
    // A subnormal carry into the hidden position lands on exponent 1.
    exp_fin = (tiny ? '0 : {s1_q.exp[EW-1], s1_q.exp}) + {{EW{1'b0}}, frac_sum[MANT_WIDTH]};
    uf      = tiny & inexact;
`else
    exp_fin = {s1_q.exp[EW-1], s1_q.exp} + {{EW{1'b0}}, frac_sum[MANT_WIDTH]};
    uf      = 1'b0;
`endif
    ovf    = exp_fin >= EXP_OVF;
    to_inf = (rm_eff == RM_RNE) | (rm_eff == RM_RMM) |
             ((rm_eff == RM_RUP) & ~s1_q.sign) | ((rm_eff == RM_RDN) & s1_q.sign);
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_load) begin
      s2_d.tag = s1_q.tag;
      if (s1_q.zero) begin
        s2_d.result = {s1_q.sign, {(RW-1){1'b0}}};
        s2_d.flags  = 5'b00000;
      end
`ifndef FPU_NORM_SUBNORM_EN
      else if (tiny) begin
        s2_d.result = {s1_q.sign, {(RW-1){1'b0}}};
        s2_d.flags  = 5'b00011;
      end
`endif
      else if (ovf) begin
        s2_d.flags = 5'b00101;
        if (to_inf) s2_d.result = {s1_q.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        else        s2_d.result = {s1_q.sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
      end else begin
        s2_d.result = {s1_q.sign, exp_fin[EXP_WIDTH-1:0], frac_sum[MANT_WIDTH-1:0]};
        s2_d.flags  = {3'b000, uf, inexact};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign out_result_o = s2_q.result;
  assign out_flags_o  = s2_q.flags;
  assign out_tag_o    = s2_q.tag;
endmodule

// File: tb/tb_fpu_norm_round.sv
// Bench for fpu_norm_round: value-based rounding model, directed vectors, backpressure, flush and random traffic.
module tb_fpu_norm_round;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        in_sign_i = 1'b0;
  logic [9:0]  in_exp_i = '0;
  logic [26:0] in_mant_i = '0;
  logic [2:0]  in_rm_i = '0;
  logic [3:0]  in_tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_result_o;
  logic [4:0]  out_flags_o;
  logic [3:0]  out_tag_o;

  fpu_norm_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_sign_i    (in_sign_i),
    .in_exp_i     (in_exp_i),
    .in_mant_i    (in_mant_i),
    .in_rm_i      (in_rm_i),
    .in_tag_i     (in_tag_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_flags_o  (out_flags_o),
    .out_tag_o    (out_tag_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  typedef struct packed {
    logic        s;
    logic [9:0]  e;
    logic [26:0] m;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       cur;
  vec_t       dir[11];
  logic [3:0] tag_ctr = '0;
  bit         rnd_ready = 1'b0;
  logic       ready_hold = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  // Reference: treat the input as an integer significand, discard low bits, round by value.
  function automatic logic [36:0] model(input logic s, input logic [9:0] e_in,
                                        input logic [26:0] m, input logic [2:0] rm_in);
    int     p, e, disc;
    longint mm, q, rem, half;
    logic   up, nx, tiny;
    logic [2:0] rm;
    if (m == 0) return {s, 31'b0, 5'b0};
    p = 0;
    for (int i = 0; i < 27; i++) if (m[i]) p = i;
    e    = int'($signed(e_in)) + p - 25;
    rm   = (rm_in > 3'd4) ? 3'd0 : rm_in;
    tiny = (e <= 0);
`ifndef FPU_NORM_SUBNORM_EN
    if (tiny) return {s, 31'b0, 5'b00011};
`endif
    disc = p - 23 + (tiny ? 1 - e : 0);
    if (disc > 30) disc = 30;
    mm = longint'(m);
    if (disc <= 0) begin
      q = mm << (-disc); rem = 0; half = 1;
    end else begin
      q = mm >> disc; rem = mm & ((longint'(1) << disc) - 1); half = longint'(1) << (disc - 1);
    end
    nx = (rem != 0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = nx & s;
      3'd3:    up = nx & ~s;
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || (rem == half && q[0]);
    endcase
    q = q + longint'(up);
    if (tiny) return {s, 7'b0, q[23], q[22:0], 3'b000, nx, nx};
    if (q >= 64'sd16777216) begin e = e + 1; q = q >> 1; end
    if (e >= 255) begin
      if (rm == 3'd0 || rm == 3'd4 || (rm == 3'd3 && !s) || (rm == 3'd2 && s))
        return {s, 8'hFF, 23'h0, 5'b00101};
      return {s, 8'hFE, 23'h7FFFFF, 5'b00101};
    end
    return {s, 8'(e), q[22:0], 4'b0000, nx};
  endfunction

  task automatic send(input logic s, input logic [9:0] e, input logic [26:0] m,
                      input logic [2:0] rm, input logic [31:0] res, input logic [4:0] fl);
    int n = 0;
    in_valid_i = 1'b1; in_sign_i = s; in_exp_i = e; in_mant_i = m; in_rm_i = rm; in_tag_i = tag_ctr;
    @(negedge clk);
    while (!in_ready_o && n < 1000) begin @(negedge clk); n++; end
    if (!in_ready_o) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready_o stayed %b required 1", in_ready_o);
      in_valid_i = 1'b0;
      return;
    end
    exp_q.push_back({tag_ctr, res, fl});
    tag_ctr = tag_ctr + 4'd1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic send_rand();
    logic s; logic [9:0] e; logic [26:0] m; logic [2:0] rm; logic [36:0] x; int ei, w;
    s  = 1'($urandom_range(0, 1));
    ei = int'($urandom_range(0, 320)) - 30;
    e  = 10'(ei);
    w  = int'($urandom_range(0, 27));
    m  = 27'($urandom) & ((27'd1 << w) - 27'd1);
    rm = 3'($urandom_range(0, 7));
    x  = model(s, e, m, rm);
    send(s, e, m, rm, x[36:5], x[4:0]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output got res=%h tag=%h required none", out_result_o, out_tag_o);
      end else begin
        cur = exp_q.pop_front();
        chk("out_result", 64'(out_result_o), 64'(cur.res));
        chk("out_flags", 64'(out_flags_o), 64'(cur.fl));
        chk("out_tag", 64'(out_tag_o), 64'(cur.tag));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dir[0]  = {1'b0, 10'd127, 27'h2000000, 3'd0, 32'h3F800000, 5'h00};
    dir[1]  = {1'b0, 10'd127, 27'h4000000, 3'd0, 32'h40000000, 5'h00};
    dir[2]  = {1'b0, 10'd152, 27'h0000001, 3'd0, 32'h3F800000, 5'h00};
    dir[3]  = {1'b0, 10'd127, 27'h2000002, 3'd0, 32'h3F800000, 5'h01};
    dir[4]  = {1'b0, 10'd127, 27'h2000006, 3'd0, 32'h3F800002, 5'h01};
    dir[5]  = {1'b0, 10'd127, 27'h2000002, 3'd3, 32'h3F800001, 5'h01};
    dir[6]  = {1'b1, 10'd127, 27'h2000002, 3'd2, 32'hBF800001, 5'h01};
    dir[7]  = {1'b0, 10'd254, 27'h7FFFFFF, 3'd0, 32'h7F800000, 5'h05};
    dir[8]  = {1'b0, 10'd254, 27'h7FFFFFF, 3'd1, 32'h7F7FFFFF, 5'h05};
    dir[9]  = {1'b1, 10'd254, 27'h0000000, 3'd0, 32'h80000000, 5'h00};
`ifdef FPU_NORM_SUBNORM_EN
    dir[10] = {1'b0, 10'd0,   27'h2000000, 3'd0, 32'h00400000, 5'h00};
`else
    dir[10] = {1'b0, 10'd0,   27'h2000000, 3'd0, 32'h00000000, 5'h03};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(out_result_o), 64'd0);
    chk("rst_flags", 64'(out_flags_o), 64'd0);
    chk("rst_tag", 64'(out_tag_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results; the first also pins latency.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("model_pin%0d", i), 64'(model(dir[i].s, dir[i].e, dir[i].m, dir[i].rm)),
          64'({dir[i].res, dir[i].fl}));
      send(dir[i].s, dir[i].e, dir[i].m, dir[i].rm, dir[i].res, dir[i].fl);
      if (i == 0) begin
        @(negedge clk) chk("lat_cycle1_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk) chk("lat_cycle2_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk); #1;
      end
    end
    drain();

    // Backpressure: four back-to-back ops, only two may be held.
    ready_hold = 1'b0;
    @(posedge clk); #2;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_held", 64'(exp_q.size()), 64'd2);
        chk("bp_in_ready", 64'(in_ready_o), 64'd0);
        chk("bp_out_valid", 64'(out_valid_o), 64'd1);
        ready_hold = 1'b1;
      end
    join
    drain();

    // Flush with two operations in flight.
    ready_hold = 1'b0;
    @(posedge clk); #2;
    send_rand();
    send_rand();
    chk("fl_pre_valid", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk) chk("fl_in_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid_o), 64'd0);
    chk("fl_in_ready_after", 64'(in_ready_o), 64'd1);
    ready_hold = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset with a full pipeline.
    ready_hold = 1'b0;
    @(posedge clk); #2;
    send_rand();
    send_rand();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    ready_hold = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random downstream stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_rand();
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();
    rnd_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
